// File: rtl/i2c_cfg_seq.sv
// Register-table sequencer: walks an external ROM after power-up and issues one
// I2C write per entry to a 16-bit-address device, optionally reading each back.
module i2c_cfg_seq #(
  parameter logic [7:0]  REG_NUM    = 8'd64,
  parameter logic [19:0] PWR_CYCLES = 20'd1_000_000,
  parameter logic [15:0] GAP_CYCLES = 16'd100,
  parameter logic        VERIFY     = 1'b0,
  parameter logic        AUTO_START = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  output logic [7:0]  cfg_idx,
  input  logic [23:0] cfg_entry,
  input  logic        i2c_end,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic        rd_en,
  output logic        i2c_start,
  output logic        addr_num,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    LOAD,
    WR_REQ,
    RD_REQ,
    GAP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] pwr_cnt_q, pwr_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        end_prev_q;
  logic [7:0]  cfg_idx_q, cfg_idx_d;
  logic [15:0] byte_addr_q, byte_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        i2c_start_q, i2c_start_d;
  logic        cfg_busy_q, cfg_busy_d;
  logic        cfg_done_q, cfg_done_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic end_rise;
  logic pwr_last;
  logic gap_last;
  logic last_entry;

  // A level already high when a request starts is stale; only a fresh edge completes it.
  assign end_rise   = i2c_end & ~end_prev_q;
  assign pwr_last   = (PWR_CYCLES <= 20'd1) || (pwr_cnt_q == PWR_CYCLES - 20'd1);
  assign gap_last   = (GAP_CYCLES <= 16'd1) || (gap_cnt_q == GAP_CYCLES - 16'd1);
  assign last_entry = (cfg_idx_q == REG_NUM - 8'd1);

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rd_pend_d   = rd_pend_q;
    cfg_idx_d   = cfg_idx_q;
    byte_addr_d = byte_addr_q;
    wr_data_d   = wr_data_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      PWR_WAIT: begin
        if (pwr_last) begin
          pwr_cnt_d = '0;
          state_d   = AUTO_START ? LOAD : IDLE;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 20'd1;
        end
      end
      IDLE, DONE: begin
        if (cfg_start) begin
          state_d   = LOAD;
          cfg_idx_d = '0;
          err_cnt_d = '0;
        end
      end
      LOAD: begin
        byte_addr_d = cfg_entry[23:8];
        wr_data_d   = cfg_entry[7:0];
        state_d     = WR_REQ;
      end
      WR_REQ: begin
        if (end_rise) begin
          if (VERIFY) begin
            rd_pend_d = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else if (last_entry) begin
            state_d = DONE;
          end else begin
            rd_pend_d = 1'b0;
            gap_cnt_d = '0;
            state_d   = GAP;
          end
        end
      end
      RD_REQ: begin
        if (end_rise) begin
          if ((rd_data != wr_data_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          rd_pend_d = 1'b0;
          if (last_entry) begin
            state_d = DONE;
          end else begin
            gap_cnt_d = '0;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          if (rd_pend_q) begin
            state_d = RD_REQ;
          end else begin
            cfg_idx_d = cfg_idx_q + 8'd1;
            state_d   = LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = PWR_WAIT;
      end
    endcase

    // Request and status outputs are registered from the next state so they change with it.
    i2c_start_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    wr_en_d     = (state_d == WR_REQ);
    rd_en_d     = (state_d == RD_REQ);
    cfg_busy_d  = (state_d != IDLE) && (state_d != DONE);
    cfg_done_d  = (state_d == DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= PWR_WAIT;
      pwr_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      end_prev_q  <= 1'b0;
      cfg_idx_q   <= '0;
      byte_addr_q <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      i2c_start_q <= 1'b0;
      cfg_busy_q  <= 1'b1;
      cfg_done_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rd_pend_q   <= rd_pend_d;
      end_prev_q  <= i2c_end;
      cfg_idx_q   <= cfg_idx_d;
      byte_addr_q <= byte_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      i2c_start_q <= i2c_start_d;
      cfg_busy_q  <= cfg_busy_d;
      cfg_done_q  <= cfg_done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cfg_idx   = cfg_idx_q;
  assign byte_addr = byte_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign i2c_start = i2c_start_q;
  assign cfg_busy  = cfg_busy_q;
  assign cfg_done  = cfg_done_q;
  assign err_cnt   = err_cnt_q;
  assign addr_num  = 1'b1;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq: instance A auto-starts with readback, instance B
// waits for cfg_start; each has a small I2C controller model answering 50 cycles later.
module tb_i2c_cfg_seq;

  logic clk;
  int   n_assert;
  int   n_fail;

  // Instance A: AUTO_START=1, VERIFY=1, GAP=5
  logic        rst_a_n, cfg_start_a, i2c_end_a, hold_a;
  logic [7:0]  cfg_idx_a, rd_data_a, err_cnt_a, wr_data_a;
  logic [23:0] cfg_entry_a;
  logic        wr_en_a, rd_en_a, i2c_start_a, addr_num_a, cfg_busy_a, cfg_done_a;
  logic [15:0] byte_addr_a;

  // Instance B: AUTO_START=0, VERIFY=1, GAP=0, readback always 0
  logic        rst_b_n, cfg_start_b, i2c_end_b;
  logic [7:0]  cfg_idx_b, rd_data_b, err_cnt_b, wr_data_b;
  logic [23:0] cfg_entry_b;
  logic        wr_en_b, rd_en_b, i2c_start_b, addr_num_b, cfg_busy_b, cfg_done_b;
  logic [15:0] byte_addr_b;

  i2c_cfg_seq #(
    .REG_NUM(8'd3), .PWR_CYCLES(20'd10), .GAP_CYCLES(16'd5),
    .VERIFY(1'b1), .AUTO_START(1'b1)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a_n), .cfg_start(cfg_start_a),
    .cfg_idx(cfg_idx_a), .cfg_entry(cfg_entry_a), .i2c_end(i2c_end_a),
    .rd_data(rd_data_a), .wr_en(wr_en_a), .rd_en(rd_en_a),
    .i2c_start(i2c_start_a), .addr_num(addr_num_a), .byte_addr(byte_addr_a),
    .wr_data(wr_data_a), .cfg_busy(cfg_busy_a), .cfg_done(cfg_done_a),
    .err_cnt(err_cnt_a)
  );

  i2c_cfg_seq #(
    .REG_NUM(8'd2), .PWR_CYCLES(20'd4), .GAP_CYCLES(16'd0),
    .VERIFY(1'b1), .AUTO_START(1'b0)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .cfg_start(cfg_start_b),
    .cfg_idx(cfg_idx_b), .cfg_entry(cfg_entry_b), .i2c_end(i2c_end_b),
    .rd_data(rd_data_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
    .i2c_start(i2c_start_b), .addr_num(addr_num_b), .byte_addr(byte_addr_b),
    .wr_data(wr_data_b), .cfg_busy(cfg_busy_b), .cfg_done(cfg_done_b),
    .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  assign cfg_entry_a = (cfg_idx_a == 8'd0) ? 24'h3103_11 :
                       (cfg_idx_a == 8'd1) ? 24'h3008_82 :
                       (cfg_idx_a == 8'd2) ? 24'h4740_21 : 24'h000000;
  assign cfg_entry_b = (cfg_idx_b == 8'd0) ? 24'hABCD_5A :
                       (cfg_idx_b == 8'd1) ? 24'h1234_C3 : 24'h000000;

  // Controller model A: remembers the last written byte, but register 0x3008 reads back 0x02.
  logic [1:0]  ma_st;
  logic [7:0]  ma_cnt, ma_wd, ma_mem;
  logic [15:0] ma_addr;
  logic        ma_end, ma_rd;

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      ma_st  <= 2'd0;
      ma_cnt <= 8'd0;
      ma_end <= 1'b0;
    end else begin
      ma_end <= 1'b0;
      case (ma_st)
        2'd0: if (i2c_start_a) begin
          ma_st   <= 2'd1;
          ma_cnt  <= 8'd1;
          ma_rd   <= rd_en_a;
          ma_addr <= byte_addr_a;
          ma_wd   <= wr_data_a;
        end
        2'd1: if (ma_cnt == 8'd49) begin
          ma_end <= 1'b1;
          ma_st  <= 2'd2;
          if (!ma_rd) ma_mem <= ma_wd;
        end else begin
          ma_cnt <= ma_cnt + 8'd1;
        end
        default: if (!i2c_start_a) ma_st <= 2'd0;
      endcase
    end
  end

  assign i2c_end_a = ma_end | hold_a;
  assign rd_data_a = (ma_addr == 16'h3008) ? 8'h02 : ma_mem;

  // Controller model B: same handshake, every read returns 0x00.
  logic [1:0] mb_st;
  logic [7:0] mb_cnt;
  logic       mb_end;

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      mb_st  <= 2'd0;
      mb_cnt <= 8'd0;
      mb_end <= 1'b0;
    end else begin
      mb_end <= 1'b0;
      case (mb_st)
        2'd0: if (i2c_start_b) begin
          mb_st  <= 2'd1;
          mb_cnt <= 8'd1;
        end
        2'd1: if (mb_cnt == 8'd49) begin
          mb_end <= 1'b1;
          mb_st  <= 2'd2;
        end else begin
          mb_cnt <= mb_cnt + 8'd1;
        end
        default: if (!i2c_start_b) mb_st <= 2'd0;
      endcase
    end
  end

  assign i2c_end_b = mb_end;
  assign rd_data_b = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle cfg_start pulse on instance A (sel=0) or B (sel=1).
  task automatic applyStimulus(input bit sel);
    if (sel) cfg_start_b = 1'b1; else cfg_start_a = 1'b1;
    step();
    cfg_start_b = 1'b0;
    cfg_start_a = 1'b0;
  endtask

  function automatic logic sigSel(input int s);
    case (s)
      0: return i2c_start_a;
      1: return i2c_start_b;
      2: return cfg_done_a;
      default: return cfg_done_b;
    endcase
  endfunction

  // Counts clock edges until the selected signal reaches lvl, giving up after max edges.
  task automatic waitLevel(input int s, input logic lvl, input int max, input string tag, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < max) begin
      step();
      n++;
      if (sigSel(s) === lvl) seen = 1'b1;
    end
    checkOutput({tag, "_reached"}, {31'd0, seen}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (wr_en_a & rd_en_a) checkOutput("a_wr_rd_exclusive", {31'd0, wr_en_a & rd_en_a}, 32'd0);
    if (wr_en_b & rd_en_b) checkOutput("b_wr_rd_exclusive", {31'd0, wr_en_b & rd_en_b}, 32'd0);
  end

  initial begin
    int n;
    n_assert = 0;
    n_fail = 0;
    clk = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    hold_a = 1'b0;
    cfg_start_a = 1'b0;
    cfg_start_b = 1'b0;

    repeat (3) step();
    checkOutput("rst_a_i2c_start", i2c_start_a, 1'b0);
    checkOutput("rst_a_wr_en", wr_en_a, 1'b0);
    checkOutput("rst_a_rd_en", rd_en_a, 1'b0);
    checkOutput("rst_a_byte_addr", byte_addr_a, 16'h0000);
    checkOutput("rst_a_wr_data", wr_data_a, 8'h00);
    checkOutput("rst_a_cfg_idx", cfg_idx_a, 8'h00);
    checkOutput("rst_a_busy", cfg_busy_a, 1'b1);
    checkOutput("rst_a_done", cfg_done_a, 1'b0);
    checkOutput("rst_a_err", err_cnt_a, 8'h00);
    checkOutput("rst_a_addr_num", addr_num_a, 1'b1);
    checkOutput("rst_b_busy", cfg_busy_b, 1'b1);

    // Instance A: power-up wait then entry 0 write on the 11th edge.
    @(negedge clk);
    rst_a_n = 1'b1;
    waitLevel(0, 1'b1, 200, "a_first_start", n);
    checkOutput("a_first_start_cycle", n, 11);
    checkOutput("a_e0_wr_en", wr_en_a, 1'b1);
    checkOutput("a_e0_rd_en", rd_en_a, 1'b0);
    checkOutput("a_e0_addr", byte_addr_a, 16'h3103);
    checkOutput("a_e0_data", wr_data_a, 8'h11);
    checkOutput("a_e0_idx", cfg_idx_a, 8'd0);
    checkOutput("a_e0_busy", cfg_busy_a, 1'b1);

    waitLevel(0, 1'b0, 200, "a_e0_wr_end", n);
    checkOutput("a_e0_wr_end_wr_en", wr_en_a, 1'b0);
    waitLevel(0, 1'b1, 200, "a_e0_rd_start", n);
    checkOutput("a_gap_wr_to_rd", n, 5);
    checkOutput("a_e0_rd_en", rd_en_a, 1'b1);
    checkOutput("a_e0_rd_wr_en", wr_en_a, 1'b0);
    checkOutput("a_e0_rd_addr", byte_addr_a, 16'h3103);
    waitLevel(0, 1'b0, 200, "a_e0_rd_end", n);
    checkOutput("a_e0_err", err_cnt_a, 8'd0);

    waitLevel(0, 1'b1, 200, "a_e1_start", n);
    checkOutput("a_gap_rd_to_wr", n, 6);
    checkOutput("a_e1_idx", cfg_idx_a, 8'd1);
    checkOutput("a_e1_addr", byte_addr_a, 16'h3008);
    checkOutput("a_e1_data", wr_data_a, 8'h82);
    checkOutput("a_e1_wr_en", wr_en_a, 1'b1);
    waitLevel(0, 1'b0, 200, "a_e1_wr_end", n);
    waitLevel(0, 1'b1, 200, "a_e1_rd_start", n);
    checkOutput("a_e1_rd_en", rd_en_a, 1'b1);
    waitLevel(0, 1'b0, 200, "a_e1_rd_end", n);
    checkOutput("a_e1_err", err_cnt_a, 8'd1);

    waitLevel(0, 1'b1, 200, "a_e2_start", n);
    checkOutput("a_e2_idx", cfg_idx_a, 8'd2);
    checkOutput("a_e2_addr", byte_addr_a, 16'h4740);
    checkOutput("a_e2_data", wr_data_a, 8'h21);
    checkOutput("a_e2_wr_en", wr_en_a, 1'b1);

    // Reset in the middle of the entry 2 write; request lines must drop without a clock edge.
    repeat (3) step();
    rst_a_n = 1'b0;
    hold_a = 1'b1;
    #1;
    checkOutput("a_midrst_start", i2c_start_a, 1'b0);
    checkOutput("a_midrst_wr_en", wr_en_a, 1'b0);
    checkOutput("a_midrst_idx", cfg_idx_a, 8'd0);
    checkOutput("a_midrst_addr", byte_addr_a, 16'h0000);
    checkOutput("a_midrst_err", err_cnt_a, 8'd0);
    checkOutput("a_midrst_busy", cfg_busy_a, 1'b1);
    @(negedge clk);
    rst_a_n = 1'b1;

    // i2c_end is already high when the first write begins: only a fresh edge may finish it.
    waitLevel(0, 1'b1, 200, "a_restart_start", n);
    checkOutput("a_restart_cycle", n, 11);
    checkOutput("a_restart_idx", cfg_idx_a, 8'd0);
    checkOutput("a_restart_addr", byte_addr_a, 16'h3103);
    repeat (80) step();
    checkOutput("a_held_end_no_done", i2c_start_a, 1'b1);
    hold_a = 1'b0;
    repeat (3) step();
    checkOutput("a_end_low_still_busy", i2c_start_a, 1'b1);
    hold_a = 1'b1;
    step();
    hold_a = 1'b0;
    checkOutput("a_fresh_edge_done", i2c_start_a, 1'b0);

    waitLevel(2, 1'b1, 3000, "a_done", n);
    checkOutput("a_done_busy", cfg_busy_a, 1'b0);
    checkOutput("a_done_err", err_cnt_a, 8'd1);
    checkOutput("a_done_idx", cfg_idx_a, 8'd2);
    checkOutput("a_done_start", i2c_start_a, 1'b0);
    checkOutput("a_done_wr_en", wr_en_a, 1'b0);
    checkOutput("a_done_rd_en", rd_en_a, 1'b0);

    // Instance B: no auto start, sits in IDLE until cfg_start.
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (10) step();
    checkOutput("b_idle_busy", cfg_busy_b, 1'b0);
    checkOutput("b_idle_done", cfg_done_b, 1'b0);
    checkOutput("b_idle_start", i2c_start_b, 1'b0);

    applyStimulus(1'b1);
    checkOutput("b_load_busy", cfg_busy_b, 1'b1);
    checkOutput("b_load_start", i2c_start_b, 1'b0);
    step();
    checkOutput("b_e0_start", i2c_start_b, 1'b1);
    checkOutput("b_e0_addr", byte_addr_b, 16'hABCD);
    checkOutput("b_e0_data", wr_data_b, 8'h5A);

    applyStimulus(1'b1);
    checkOutput("b_midrun_start_ignored", i2c_start_b, 1'b1);
    checkOutput("b_midrun_idx", cfg_idx_b, 8'd0);

    waitLevel(1, 1'b0, 200, "b_e0_wr_end", n);
    waitLevel(1, 1'b1, 200, "b_e0_rd_start", n);
    checkOutput("b_gap0_wr_to_rd", n, 1);
    checkOutput("b_e0_rd_en", rd_en_b, 1'b1);
    waitLevel(1, 1'b0, 200, "b_e0_rd_end", n);
    checkOutput("b_e0_err", err_cnt_b, 8'd1);
    waitLevel(1, 1'b1, 200, "b_e1_start", n);
    checkOutput("b_gap0_rd_to_wr", n, 2);
    checkOutput("b_e1_idx", cfg_idx_b, 8'd1);
    checkOutput("b_e1_addr", byte_addr_b, 16'h1234);
    checkOutput("b_e1_data", wr_data_b, 8'hC3);

    waitLevel(3, 1'b1, 2000, "b_done", n);
    checkOutput("b_done_busy", cfg_busy_b, 1'b0);
    checkOutput("b_done_err", err_cnt_b, 8'd2);
    checkOutput("b_done_idx", cfg_idx_b, 8'd1);

    applyStimulus(1'b1);
    checkOutput("b_restart_done", cfg_done_b, 1'b0);
    checkOutput("b_restart_busy", cfg_busy_b, 1'b1);
    checkOutput("b_restart_err", err_cnt_b, 8'd0);
    checkOutput("b_restart_idx", cfg_idx_b, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
